// File: rtl/popcount_weight_enum.sv
// ============================================================================
// Module      : popcount_weight_enum
// Description : Streams every N-bit vector of popcount k in ascending order
//               (Gosper next-combination), one vector per valid/ready
//               handshake. Optional self-check: POPCOUNT_ENUM_SELFCHECK_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module popcount_weight_enum #(
    parameter int N = 7,
    parameter int W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] weight,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_vec,
    output logic         out_last,
    output logic [N-1:0] out_index,
    output logic         done,
    output logic         bad_weight,
    output logic         chk_err
);

    localparam logic [1:0]   S_IDLE = 2'd0;
    localparam logic [1:0]   S_EMIT = 2'd1;
    localparam logic [1:0]   S_ERR  = 2'd2;
    localparam logic [W-1:0] N_K    = W'(N);
    localparam int           CW     = $clog2(N + 1) + 1;

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [W-1:0] r_k;
    logic [N-1:0] r_vec;
    logic [N-1:0] r_index;
    logic         r_done;
    logic         r_bad;

    logic         w_accept;
    logic         w_weight_bad;
    logic         w_fire;
    logic         w_valid;
    logic         w_busy;
    logic         w_is_last;
    logic [N-1:0] w_first;
    logic [N-1:0] w_last_pat;

    assign w_accept     = start && (r_state == S_IDLE);
    assign w_weight_bad = (weight > N_K);
    assign w_fire       = (r_state == S_EMIT) && out_ready;

    // First vector is the k lowest bits set; last is those bits at the top.
    assign w_first    = (N'(1) << weight) - N'(1);
    assign w_last_pat = ((N'(1) << r_k) - N'(1)) << (N_K - r_k);
    assign w_is_last  = (r_vec == w_last_pat);

    // Gosper's hack, computed one bit wider so the carry out of x + c is kept.
    logic [N:0]    w_x;
    logic [N:0]    w_c;
    logic [N:0]    w_r;
    logic [N:0]    w_sh;
    logic [N:0]    w_nxt_full;
    logic [CW-1:0] w_ctz;
    logic [N-1:0]  w_next;
    logic          w_unused_msb;

    assign w_x = {1'b0, r_vec};
    assign w_c = w_x & (-w_x);
    assign w_r = w_x + w_c;

    always_comb begin
        w_ctz = '0;
        for (int i = N; i >= 0; i--) begin
            if (w_c[i]) begin
                w_ctz = CW'(i);
            end
        end
    end

    assign w_sh         = ((w_x ^ w_r) >> 2) >> w_ctz;
    assign w_nxt_full   = w_r | w_sh;
    assign w_next       = w_nxt_full[N-1:0];
    assign w_unused_msb = w_nxt_full[N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_weight_bad ? S_ERR : S_EMIT;
                end
            end
            S_EMIT: begin
                if (w_fire && w_is_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_valid = (r_state == S_EMIT);
        w_busy  = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k     <= '0;
            r_vec   <= '0;
            r_index <= '0;
            r_done  <= 1'b0;
            r_bad   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_k     <= weight;
                r_bad   <= w_weight_bad;
                r_index <= '0;
                if (w_weight_bad) begin
                    r_done <= 1'b1;
                end else begin
                    r_vec <= w_first;
                end
            end else if (w_fire) begin
                if (w_is_last) begin
                    r_done <= 1'b1;
                end else begin
                    r_vec   <= w_next;
                    r_index <= r_index + N'(1);
                end
            end
        end
    end

    assign busy       = w_busy;
    assign out_valid  = w_valid;
    assign out_vec    = r_vec;
    assign out_last   = w_valid && w_is_last;
    assign out_index  = r_index;
    assign done       = r_done;
    assign bad_weight = r_bad;

`ifdef POPCOUNT_ENUM_SELFCHECK_EN
    localparam int P = 1 << $clog2(N);

    logic [W-1:0] w_lvl [0:P-1];
    logic [W-1:0] w_pop;
    logic [N-1:0] r_prev;
    logic         r_have_prev;
    logic         r_chk;

    // Pairwise reduction: each pass halves the number of partial sums.
    always_comb begin
        w_lvl = '{default: '0};
        for (int j = 0; j < N; j++) begin
            w_lvl[j] = W'(r_vec[j]);
        end
        for (int s = P / 2; s >= 1; s = s / 2) begin
            for (int j = 0; j < s; j++) begin
                w_lvl[j] = w_lvl[2*j] + w_lvl[2*j+1];
            end
        end
        w_pop = w_lvl[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev      <= '0;
            r_have_prev <= 1'b0;
            r_chk       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_have_prev <= 1'b0;
            end else if (w_fire) begin
                r_prev      <= r_vec;
                r_have_prev <= 1'b1;
                if ((w_pop != r_k) || (r_have_prev && (r_vec <= r_prev))) begin
                    r_chk <= 1'b1;
                end
            end
        end
    end

    assign chk_err = r_chk;
`else
    assign chk_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/popcount_weight_enum.md
Name: popcount_weight_enum

Overview:
- Inverse companion of the popcount07 approximate counters: given a target weight k, streams every N-bit input vector whose exact popcount is k.
- Emits one vector per handshake in ascending numeric order (Gosper next-combination).
- Used as on-chip stimulus for exhaustive, per-weight error characterisation of approximate popcount circuits (MAE/WCE per output value).

Parameters:
- N, 7, input vector width of the popcount under test (2..16)
- W, $clog2(N+1), width of the weight input (3 for N=7)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request enumeration; accepted only when busy=0
- weight  in  W  target popcount k, sampled on accepted start
- busy  out  1  high from accepted start until final handshake or error completion
- out_valid  out  1  out_vec/out_last/out_index are valid
- out_ready  in  1  downstream accepts current vector
- out_vec  out  N  current vector, popcount == k
- out_last  out  1  current vector is the final one for k
- out_index  out  N  zero-based ordinal of current vector
- done  out  1  one-cycle pulse after final handshake or error
- bad_weight  out  1  sticky: last accepted start had k>N; cleared by next accepted start
- chk_err  out  1  self-check mismatch, sticky (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, out_valid, out_last, done, bad_weight, chk_err = 0; out_vec and out_index = 0. Takes effect mid-stream with no completion pulse.
- States:
  - IDLE: on start=1, latch k and go to EMIT, or to ERR if k>N; start ignored while busy.
  - EMIT: hold out_valid=1.
  - ERR: one cycle with done=1 and bad_weight set, then IDLE; no vector emitted.
- Latency: start accepted in cycle t → out_valid=1 in cycle t+1 with out_vec=(1<<k)-1 and out_index=0.
- Handshake:
  - While out_valid=1 and out_ready=0: out_vec, out_last and out_index are held stable.
  - Transfer on out_valid & out_ready.
  - Next vector is presented the following cycle, giving zero bubbles: one vector per cycle with out_ready held high.
- Next vector (combinational from out_vec=x):
  - c = x & -x
  - r = x + c
  - next = r | (((x ^ r) >> 2) >> ctz(c))
  - ctz uses a priority encoder, not a divider.
  - Arithmetic is done at N+1 bits; bit N is discarded.
- out_last=1 iff x == ((1<<k)-1) << (N-k).
- Transfer with out_last=1: next cycle out_valid=0, busy=0, done=1 (single cycle), state IDLE.
- Boundary cases:
  - k=0: single vector 0 with out_last=1.
  - k=N: single vector all-ones with out_last=1.
- Vector count is C(N,k): 1, 7, 21, 35, 35, 21, 7, 1 for k=0..7 with N=7.
- out_index increments by 1 per transfer. Maximum is C(N,N/2)-1, which fits in N bits with no wrap.
- Start arriving in the same cycle as the final transfer is ignored (busy still 1).

Optional Feature:
- Macro POPCOUNT_ENUM_SELFCHECK_EN.
- Defined:
  - An exact adder-tree popcount of out_vec is compared against latched k on every transfer.
  - An ordering check confirms each vector is strictly greater than the previous one.
  - Any failure sets chk_err, which stays set until reset.
- Undefined: chk_err tied to 0 and no check logic is synthesised.

Test Plan:
- Reset mid-stream (k=3, after 10 transfers) → all outputs 0 immediately; next start k=2 begins at out_vec=7'b0000011, out_index=0.
- start, k=3, out_ready=1:
  - Exactly 35 vectors, first 0000111, second 0001011, last 1110000 with out_last=1 and out_index=34.
  - done pulses one cycle after the last transfer.
- k=0, then k=7:
  - k=0 → one vector 0000000 with out_last=1.
  - k=7 → one vector 1111111 with out_last=1.
  - done after each.
- Backpressure, k=2: out_ready toggled randomly → every vector held stable while stalled; 21 unique vectors in ascending order, none dropped or duplicated.
- Bad weight: N=7 with W widened to 4 via override, k=8 → no out_valid; done pulse in cycle t+1; bad_weight=1 until the next valid start.
- With POPCOUNT_ENUM_SELFCHECK_EN, sweep k=0..7 back-to-back:
  - 128 total vectors.
  - chk_err stays 0.
  - Forcing an out_vec bit flip via the bench sets chk_err=1.
